// File: rtl/buf_addr_counter_if.sv
// Control and status bundle between a buffer port client and its address counter.
// Carries no state; the counter registers everything except tc.
// No backpressure; the client strobes en one step per cycle.
interface buf_addr_counter_if #(
  parameter int width     = 16,
  parameter int buf_width = 2
);
  logic                 clear;
  logic                 load;
  logic [width-1:0]     load_val;
  logic                 en;
  logic                 up;
  logic                 buf_lock;
  logic [width-1:0]     count;
  logic [buf_width-1:0] buf_sel;
  logic                 wrap;
  logic                 tc;
  logic                 overrun;

  modport master (
    output clear, load, load_val, en, up, buf_lock,
    input  count, buf_sel, wrap, tc, overrun
  );

  modport slave (
    input  clear, load, load_val, en, up, buf_lock,
    output count, buf_sel, wrap, tc, overrun
  );
endinterface

// File: rtl/buf_addr_counter.sv
// Modulo address counter that rotates a bank select on every wrap.
// count/buf_sel/wrap/overrun: 1 cycle after the control edge; tc combinational.
// No backpressure; buf_lock blocks bank rotation and flags overrun.
module buf_addr_counter #(
  parameter int          width     = 16,
  parameter int unsigned depth     = 1024,
  parameter int unsigned num_buf   = 3,
  parameter int          buf_width = 2
) (
  input  logic           clk,
  input  logic           reset,
  buf_addr_counter_if.slave bus
);

  localparam logic [width-1:0]     last_addr = width'(depth - 1);
  localparam logic [width:0]       depth_ext = (width + 1)'(depth);
  localparam logic [buf_width-1:0] last_buf  = buf_width'(num_buf - 1);

  logic [width-1:0]     count_q,   count_d;
  logic [buf_width-1:0] buf_sel_q, buf_sel_d;
  logic                 wrap_q,    wrap_d;
  logic                 overrun_q, overrun_d;
  logic                 at_end;

  // Terminal position depends on direction: top when counting up, zero when down.
  assign at_end = bus.up ? (count_q == last_addr) : (count_q == '0);

  always_comb begin
    count_d   = count_q;
    buf_sel_d = buf_sel_q;
    wrap_d    = 1'b0;
    overrun_d = overrun_q;

    if (bus.clear) begin
      count_d   = '0;
      buf_sel_d = '0;
      overrun_d = 1'b0;
    end else if (bus.load) begin
      count_d = ({1'b0, bus.load_val} < depth_ext) ? bus.load_val : last_addr;
    end else if (bus.en) begin
      if (bus.up) begin
        count_d = at_end ? '0 : count_q + 1'b1;
      end else begin
        count_d = at_end ? last_addr : count_q - 1'b1;
      end

      if (at_end) begin
        wrap_d = 1'b1;
        if (bus.buf_lock) begin
          overrun_d = 1'b1;
        end else if (bus.up) begin
          buf_sel_d = (buf_sel_q == last_buf) ? '0 : buf_sel_q + 1'b1;
        end else begin
          buf_sel_d = (buf_sel_q == '0) ? last_buf : buf_sel_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      buf_sel_q <= '0;
      wrap_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      buf_sel_q <= buf_sel_d;
      wrap_q    <= wrap_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.buf_sel = buf_sel_q;
  assign bus.wrap    = wrap_q;
  assign bus.overrun = overrun_q;
  assign bus.tc      = bus.en & at_end;

endmodule
